// File: rtl/GLOBAL_PARAM.sv
// Shared parameters, width helper and FSM state encoding for the ddr2buf block family.
package GLOBAL_PARAM;

  localparam int unsigned DDR_W = 512;

  // Bits needed to address v distinct values (minimum 1).
  function automatic int unsigned bw(input int unsigned v);
    int unsigned w = 1;
    while ((64'd1 << w) < 64'(v)) w++;
    return w;
  endfunction

  typedef enum logic [1:0] {
    DDR2BUF_IDLE  = 2'd0,
    DDR2BUF_RUN   = 2'd1,
    DDR2BUF_DRAIN = 2'd2,
    DDR2BUF_DONE  = 2'd3
  } ddr2buf_state_e;

endpackage

// File: rtl/ddr2buf_unpack.sv
// Unpacks wide DDR stream beats into one-element-per-cycle buffer writes,
// broadcasting each element to the banks selected at job start.
module ddr2buf_unpack #(
  parameter int unsigned DDR_W    = GLOBAL_PARAM::DDR_W,
  parameter int unsigned ELEM_W   = 16,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned BANK_NUM = 4,
  parameter int unsigned ADDR_W   = GLOBAL_PARAM::bw(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                done,
  input  logic [ADDR_W:0]     elem_num,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [BANK_NUM-1:0] bank_mask,
  input  logic [DDR_W-1:0]    ddr_data,
  input  logic                ddr_valid,
  output logic                ddr_ready,
  output logic [ELEM_W-1:0]   wr_data,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [BANK_NUM-1:0] wr_en,
  output logic                busy
);
  import GLOBAL_PARAM::*;

  localparam int unsigned BATCH = DDR_W / ELEM_W;
  localparam int unsigned PTR_W = bw(BATCH);
  localparam int unsigned CNT_W = bw(DEPTH + BATCH) + 1;

  ddr2buf_state_e      state_q, state_d;
  logic [DDR_W-1:0]    beat_q, beat_d;
  logic                full_q, full_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [ADDR_W:0]     num_q, num_d;
  logic [BANK_NUM-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d;
  logic [CNT_W-1:0]    acc_q, acc_d;

  logic wr_fire, last_in_beat, last_elem, accept;

  // Next-state: job control, beat register (shifted so the current element sits at the LSBs), counters.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    full_d  = full_q;
    ptr_d   = ptr_q;
    num_d   = num_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    acc_d   = acc_q;

    wr_fire      = full_q;
    last_in_beat = (ptr_q == PTR_W'(BATCH - 1));
    last_elem    = ((wcnt_q + CNT_W'(1)) == CNT_W'(num_q));
    ddr_ready    = (state_q == DDR2BUF_RUN) && (!full_q || last_in_beat);
    accept       = ddr_ready && ddr_valid;

    unique case (state_q)
      DDR2BUF_IDLE: begin
        if (start) begin
          num_d   = elem_num;
          mask_d  = bank_mask;
          addr_d  = base_addr;
          wcnt_d  = '0;
          acc_d   = '0;
          state_d = (elem_num == '0) ? DDR2BUF_DONE : DDR2BUF_RUN;
        end
      end
      DDR2BUF_RUN: begin
        if (accept && ((acc_q + CNT_W'(BATCH)) >= CNT_W'(num_q))) state_d = DDR2BUF_DRAIN;
      end
      DDR2BUF_DRAIN: begin
        if (wr_fire && last_elem) state_d = DDR2BUF_DONE;
      end
      default: state_d = DDR2BUF_IDLE;
    endcase

    if (wr_fire) begin
      wcnt_d = wcnt_q + CNT_W'(1);
      addr_d = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
      beat_d = beat_q >> ELEM_W;
      ptr_d  = ptr_q + PTR_W'(1);
      // Tail elements of the final beat beyond elem_num are dropped here.
      if (last_in_beat || last_elem) begin
        full_d = 1'b0;
        ptr_d  = '0;
      end
    end

    if (accept) begin
      beat_d = ddr_data;
      full_d = 1'b1;
      ptr_d  = '0;
      acc_d  = acc_q + CNT_W'(BATCH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DDR2BUF_IDLE;
      beat_q  <= '0;
      full_q  <= 1'b0;
      ptr_q   <= '0;
      num_q   <= '0;
      mask_q  <= '0;
      addr_q  <= '0;
      wcnt_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      full_q  <= full_d;
      ptr_q   <= ptr_d;
      num_q   <= num_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      acc_q   <= acc_d;
    end
  end

  // Outputs are pure decodes of registered state; gated to zero off write cycles.
  assign wr_en   = wr_fire ? mask_q : '0;
  assign wr_data = wr_fire ? beat_q[ELEM_W-1:0] : '0;
  assign wr_addr = wr_fire ? addr_q : '0;
  assign done    = (state_q == DDR2BUF_DONE);
  assign busy    = (state_q != DDR2BUF_IDLE);

endmodule

// File: tb/tb_ddr2buf_unpack.sv
// Table-driven job bench for ddr2buf_unpack with a write scoreboard.
module tb_ddr2buf_unpack;
  localparam int unsigned DDR_W    = 512;
  localparam int unsigned ELEM_W   = 16;
  localparam int unsigned DEPTH    = 256;
  localparam int unsigned BANK_NUM = 4;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned BATCH    = DDR_W / ELEM_W;
  localparam int          NVEC     = 11;

  logic                clk = 1'b0;
  logic                rst, start, done, ddr_valid, ddr_ready, busy;
  logic [ADDR_W:0]     elem_num;
  logic [ADDR_W-1:0]   base_addr, wr_addr;
  logic [BANK_NUM-1:0] bank_mask, wr_en;
  logic [DDR_W-1:0]    ddr_data;
  logic [ELEM_W-1:0]   wr_data;

  always #5 clk = ~clk;

  ddr2buf_unpack #(
    .DDR_W(DDR_W), .ELEM_W(ELEM_W), .DEPTH(DEPTH), .BANK_NUM(BANK_NUM)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .done(done),
    .elem_num(elem_num), .base_addr(base_addr), .bank_mask(bank_mask),
    .ddr_data(ddr_data), .ddr_valid(ddr_valid), .ddr_ready(ddr_ready),
    .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en), .busy(busy)
  );

  typedef struct {
    int n; int base; int mask; bit gaps; bit poke; int abort_at;
    int exp_beats; int exp_lat;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0]   addr;
    logic [ELEM_W-1:0]   data;
    logic [BANK_NUM-1:0] en;
  } wr_t;

  wr_t  exp_q[$];
  vec_t vecs[NVEC];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [ELEM_W-1:0] elem_val(input int e, input int base);
    return ELEM_W'(e * 37 + base * 11 + 5);
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk($sformatf("%s done", tag), longint'(done), 0);
    chk($sformatf("%s busy", tag), longint'(busy), 0);
    chk($sformatf("%s ddr_ready", tag), longint'(ddr_ready), 0);
    chk($sformatf("%s wr_en", tag), longint'(wr_en), 0);
    chk($sformatf("%s wr_data", tag), longint'(wr_data), 0);
    chk($sformatf("%s wr_addr", tag), longint'(wr_addr), 0);
  endtask

  // Drive one job; outputs are observed and inputs changed on the falling edge.
  task automatic run_job(input int idx, input vec_t v);
    int               cycle, beat, done_cycle;
    bit               done_seen;
    logic [DDR_W-1:0] bd;
    wr_t              w;
    exp_q.delete();
    for (int e = 0; e < v.n; e++) begin
      w.addr = ADDR_W'((v.base + e) % DEPTH);
      w.data = elem_val(e, v.base);
      w.en   = BANK_NUM'(v.mask);
      exp_q.push_back(w);
    end
    start = 1'b1; elem_num = (ADDR_W+1)'(v.n);
    base_addr = ADDR_W'(v.base); bank_mask = BANK_NUM'(v.mask); ddr_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; cycle = 1; beat = 0; done_seen = 0; done_cycle = -1;
    while (!done_seen && cycle < 3000) begin
      if (wr_en != '0) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("job%0d extra_write", idx), longint'(wr_en), 0);
        end else begin
          w = exp_q.pop_front();
          chk($sformatf("job%0d wr_addr", idx), longint'(wr_addr), longint'(w.addr));
          chk($sformatf("job%0d wr_data", idx), longint'(wr_data), longint'(w.data));
          chk($sformatf("job%0d wr_en", idx), longint'(wr_en), longint'(w.en));
        end
      end
      chk($sformatf("job%0d ready_after_last_beat", idx), longint'(ddr_ready && beat >= v.exp_beats), 0);
      chk($sformatf("job%0d busy", idx), longint'(busy), 1);
      if (done) begin
        done_seen = 1; done_cycle = cycle;
      end
      if (v.abort_at > 0 && cycle == v.abort_at) begin
        rst = 1'b1; ddr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_outputs($sformatf("job%0d after_abort", idx));
        repeat (10) begin
          @(negedge clk);
          chk($sformatf("job%0d aborted_done", idx), longint'(done), 0);
          chk($sformatf("job%0d aborted_wr_en", idx), longint'(wr_en), 0);
        end
        exp_q.delete();
        return;
      end
      start = v.poke && cycle == 10;
      if (start) begin
        elem_num = 9'd5; base_addr = 8'd0; bank_mask = 4'hF;
      end
      ddr_valid = v.gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      for (int i = 0; i < BATCH; i++) bd[i*ELEM_W +: ELEM_W] = elem_val(beat * BATCH + i, v.base);
      ddr_data = bd;
      if (ddr_valid && ddr_ready) beat++;
      @(negedge clk);
      cycle++;
    end
    start = 1'b0; ddr_valid = 1'b0;
    chk($sformatf("job%0d done_seen", idx), longint'(done_seen), 1);
    chk($sformatf("job%0d missing_writes", idx), longint'(exp_q.size()), 0);
    chk($sformatf("job%0d beats", idx), longint'(beat), longint'(v.exp_beats));
    if (v.exp_lat >= 0) chk($sformatf("job%0d latency", idx), longint'(done_cycle), longint'(v.exp_lat));
    chk($sformatf("job%0d done_one_cycle", idx), longint'(done), 0);
    chk($sformatf("job%0d busy_after_done", idx), longint'(busy), 0);
  endtask

  initial begin
    //          n    base mask gaps poke abort beats lat
    vecs[0]  = '{64,  0,   1,   0,   0,   0,    2,    66};
    vecs[1]  = '{33,  0,   15,  0,   0,   0,    2,    35};
    vecs[2]  = '{10,  250, 2,   0,   0,   0,    1,    12};
    vecs[3]  = '{200, 17,  5,   1,   0,   0,    7,    -1};
    vecs[4]  = '{200, 17,  5,   0,   0,   0,    7,    202};
    vecs[5]  = '{0,   3,   15,  0,   0,   0,    0,    1};
    vecs[6]  = '{100, 5,   3,   0,   0,   20,   4,    -1};
    vecs[7]  = '{40,  100, 8,   0,   0,   0,    2,    42};
    vecs[8]  = '{256, 128, 1,   0,   0,   0,    8,    258};
    vecs[9]  = '{1,   255, 4,   0,   0,   0,    1,    3};
    vecs[10] = '{31,  0,   1,   0,   1,   0,    1,    33};

    rst = 1'b1; start = 1'b0; ddr_valid = 1'b0; ddr_data = '0;
    elem_num = '0; base_addr = '0; bank_mask = '0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("idle");

    for (int k = 0; k < NVEC; k++) begin
      run_job(k, vecs[k]);
      repeat (2) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
